// File: rtl/param_const_checker_pkg.sv
// Shared types and default constants for the parameterized-constant checker.
package param_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PASS   = 2'd2,
        ST_FAIL   = 2'd3
    } state_e;

    localparam int unsigned SETTLE_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 8;

endpackage

// File: rtl/param_const_checker_stable_counter.sv
// Tracks the most recent sample and the length of the current run of equal samples.
module stable_counter
    import param_check_pkg::*;
#(
    parameter int unsigned W      = 2,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] val,
    output logic [W-1:0] last_val,
    output logic         stable
);

    localparam int unsigned RW = $clog2(SETTLE + 1);

    logic [RW-1:0] run_cnt;

    assign stable = (run_cnt == RW'(SETTLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            last_val <= '0;
        end else if (clr) begin
            run_cnt <= '0;
        end else if (en) begin
            // run length saturates at SETTLE so it cannot wrap after the verdict
            if (run_cnt == '0 || val == last_val) begin
                if (!stable) run_cnt <= run_cnt + 1'b1;
            end else begin
                run_cnt <= RW'(1);
            end
            last_val <= val;
        end
    end

endmodule

// File: rtl/param_const_checker.sv
// Waits for a constant input to settle, checks it against EXP, then watches for deviations.
module param_const_checker
    import param_check_pkg::*;
#(
    parameter int unsigned   W       = 2,
    parameter logic [W-1:0]  EXP     = W'(2'b10),
    parameter int unsigned   SETTLE  = SETTLE_DEF,
    parameter int unsigned   TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned   CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     val,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [W-1:0]     last_val
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_cnt;
    logic          stable;
    logic          tmo_fire;
    logic          clr;
    logic          trk_en;
    logic          watching;

    assign clr      = (state_q == ST_IDLE) && en;
    assign trk_en   = en && (state_q != ST_IDLE);
    assign watching = (state_q == ST_PASS) || (state_q == ST_FAIL);

    stable_counter #(
        .W      (W),
        .SETTLE (SETTLE)
    ) u_stable (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .en       (trk_en),
        .val      (val),
        .last_val (last_val),
        .stable   (stable)
    );

    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (stable) begin
                    state_d = (last_val == EXP) ? ST_PASS : ST_FAIL;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_d  = ST_FAIL;
                    tmo_fire = 1'b1;
                end
            end
            ST_PASS: begin
                if (!en)             state_d = ST_IDLE;
                else if (val != EXP) state_d = ST_FAIL;
            end
            ST_FAIL: begin
                if (!en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmo_cnt      <= '0;
            mismatch_cnt <= '0;
            timeout      <= 1'b0;
        end else begin
            state_q <= state_d;
            // timeout flag survives only while the FAIL it caused persists
            timeout <= (state_d == ST_FAIL) && (tmo_fire || timeout);
            if (clr) begin
                tmo_cnt      <= '0;
                mismatch_cnt <= '0;
            end else begin
                if (en && state_q == ST_SETTLE) tmo_cnt <= tmo_cnt + 1'b1;
                if (en && watching && val != EXP && mismatch_cnt != '1)
                    mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end

    assign pass = (state_q == ST_PASS);
    assign fail = (state_q == ST_FAIL);
    assign done = pass | fail;

endmodule

// File: tb/tb_param_const_checker.sv
// Randomized and directed checks of param_const_checker against a behavioural model.
module tb_param_const_checker;

    localparam int unsigned W       = 2;
    localparam logic [1:0]  EXP     = 2'b10;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] val;

    logic       done_a, pass_a, fail_a, tmo_a;
    logic [7:0] mis_a;
    logic [1:0] last_a;
    logic       done_b, pass_b, fail_b, tmo_b;
    logic [1:0] mis_b;
    logic [1:0] last_b;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // model: 0 idle, 1 settling, 2 good verdict, 3 bad verdict
    int          m_phase;
    int          m_run;
    int          m_elapsed;
    logic [1:0]  m_last;
    int          m_mis_a;
    int          m_mis_b;
    logic        m_tmo;

    always #5 clk = ~clk;

    param_const_checker #(
        .W (W), .EXP (EXP), .SETTLE (SETTLE), .TIMEOUT (TIMEOUT), .CNT_W (8)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .en (en), .val (val),
        .done (done_a), .pass (pass_a), .fail (fail_a), .timeout (tmo_a),
        .mismatch_cnt (mis_a), .last_val (last_a)
    );

    param_const_checker #(
        .W (W), .EXP (EXP), .SETTLE (SETTLE), .TIMEOUT (TIMEOUT), .CNT_W (2)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en), .val (val),
        .done (done_b), .pass (pass_b), .fail (fail_b), .timeout (tmo_b),
        .mismatch_cnt (mis_b), .last_val (last_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_run = 0; m_elapsed = 0; m_last = '0;
        m_mis_a = 0; m_mis_b = 0; m_tmo = 1'b0;
    endtask

    task automatic model_step();
        if (!en) begin
            m_phase = 0;
            m_tmo   = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_phase = 1; m_run = 0; m_elapsed = 0;
                    m_mis_a = 0; m_mis_b = 0; m_tmo = 1'b0;
                end
                1: begin
                    if (m_run >= SETTLE) m_phase = (m_last == EXP) ? 2 : 3;
                    else if (m_elapsed == TIMEOUT - 1) begin
                        m_phase = 3; m_tmo = 1'b1;
                    end
                    m_run = (m_run == 0 || val == m_last) ? m_run + 1 : 1;
                    m_last = val;
                    m_elapsed++;
                end
                default: begin
                    if (val != EXP) begin
                        m_mis_a = (m_mis_a < 255) ? m_mis_a + 1 : 255;
                        m_mis_b = (m_mis_b < 3) ? m_mis_b + 1 : 3;
                        m_phase = 3;
                    end
                    m_last = val;
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".done_a"}, done_a, m_phase >= 2);
        check({tag, ".pass_a"}, pass_a, m_phase == 2);
        check({tag, ".fail_a"}, fail_a, m_phase == 3);
        check({tag, ".tmo_a"},  tmo_a,  m_tmo);
        check({tag, ".mis_a"},  mis_a,  m_mis_a);
        check({tag, ".last_a"}, last_a, m_last);
        check({tag, ".done_b"}, done_b, m_phase >= 2);
        check({tag, ".fail_b"}, fail_b, m_phase == 3);
        check({tag, ".mis_b"},  mis_b,  m_mis_b);
        check({tag, ".last_b"}, last_b, m_last);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; val = '0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // constant expected value: verdict after SETTLE+1 edges
        en = 1'b1; val = 2'b10;
        for (int i = 0; i < 5; i++) cycle("const_ok");
        check("ok_done_latency", done_a, 1'b0);
        cycle("const_ok");
        check("ok_pass", pass_a, 1'b1);
        check("ok_mis", mis_a, 0);
        cycle("const_ok");

        // drop enable while in PASS: verdict clears, count holds
        en = 1'b0;
        cycle("drop_en");
        check("drop_pass", pass_a, 1'b0);

        // constant wrong value
        en = 1'b1; val = 2'b01;
        for (int i = 0; i < 8; i++) cycle("const_bad");
        check("bad_fail", fail_a, 1'b1);
        check("bad_tmo", tmo_a, 1'b0);

        // pass, then three bad cycles, then more for saturation
        en = 1'b0; cycle("idle");
        en = 1'b1; val = 2'b10;
        for (int i = 0; i < 7; i++) cycle("pre_mis");
        val = 2'b01;
        for (int i = 0; i < 3; i++) cycle("post_mis");
        check("mis3_a", mis_a, 3);
        check("mis3_done", done_a, 1'b1);
        for (int i = 0; i < 5; i++) cycle("sat");
        check("sat_b", mis_b, 3);
        check("sat_a", mis_a, 8);

        // toggling every two cycles never settles
        en = 1'b0; cycle("idle");
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            val = ((i / 2) % 2 != 0) ? 2'b01 : 2'b10;
            cycle("toggle");
        end
        check("toggle_tmo", tmo_a, 1'b1);
        check("toggle_fail", fail_a, 1'b1);

        // asynchronous reset mid-settle
        en = 1'b0; cycle("idle");
        en = 1'b1; val = 2'b10;
        for (int i = 0; i < 3; i++) cycle("pre_rst");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk); #1;
        en = 1'b0; rst_n = 1'b1;
        cycle("post_rst");

        // randomized stream, mostly sticky values and mostly enabled
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 7) == 0)
                val = ($urandom_range(0, 3) < 2) ? EXP : 2'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_const_checker.md
# param_const_checker

Sequential sink for constant-valued outputs of parameterized modules, such as a nested-parameter constant source whose output resolves to a fixed W-bit word. After enable, it waits for the input to hold one value for SETTLE consecutive cycles, then compares that value against the expected parameter EXP. It then stays in a verdict state and keeps watching for later deviations. It sits in self-checking test tops on the consuming side of the parameterized source.

## Interface
Parameters:
- W, 2, width of checked value
- EXP, 2'b10, expected constant value, W bits
- SETTLE, 4, consecutive equal samples required before verdict (≥1)
- TIMEOUT, 32, max cycles in SETTLE before forced fail (> SETTLE)
- CNT_W, 8, width of mismatch counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  level enable; 1 = run check, 0 = return to IDLE
- val  in  W  value driven by the parameterized source
- done  out  1  verdict reached
- pass  out  1  verdict pass, no later mismatch
- fail  out  1  verdict fail (sticky until IDLE)
- timeout  out  1  fail caused by SETTLE timeout
- mismatch_cnt  out  CNT_W  post-verdict cycles with val≠EXP, saturating
- last_val  out  W  most recent sampled val

## Operation
- States: IDLE, SETTLE, PASS, FAIL.
- IDLE: en=1 → SETTLE. The same transition clears run_cnt, tmo_cnt, mismatch_cnt, done/pass/fail/timeout.
- SETTLE, each edge:
  - run_cnt==0 or val==last_val → run_cnt+1.
  - Otherwise run_cnt←1.
  - last_val←val in both cases.
  - tmo_cnt+1 on every edge.
- SETTLE decision, checked before the update above. Priority order:
  1. en=0 → IDLE.
  2. run_cnt==SETTLE → PASS if last_val==EXP, else FAIL.
  3. tmo_cnt==TIMEOUT-1 → FAIL with timeout=1.
- PASS/FAIL, each edge:
  - val≠EXP → mismatch_cnt+1, saturating at 2^CNT_W−1.
  - PASS with val≠EXP → FAIL.
  - FAIL never returns to PASS.
  - last_val keeps tracking val.
- en=0 in any state → IDLE at next edge. done/pass/fail/timeout clear; mismatch_cnt and last_val hold.
- en=0 coincident with a mismatch in PASS/FAIL: go to IDLE, no increment.
- Outputs are registered; pass = (state==PASS), fail = (state==FAIL), done = pass|fail.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0; run_cnt=tmo_cnt=0. Valid combinationally on assertion. Release is synchronous to the next edge.
- Constant val, en sampled high at edge 0:
  - SETTLE from edge 0.
  - run_cnt reaches SETTLE at edge SETTLE.
  - Verdict at edge SETTLE+1; done visible after it. Latency is SETTLE+1 cycles (5 for default).
- Any change of val during SETTLE restarts the run at 1.
- Timeout verdict at edge TIMEOUT after entry (32 for default).
- Post-verdict mismatch: fail/mismatch_cnt update at the edge sampling the bad val (1-cycle latency).
- Reset mid-operation: immediate IDLE; a new check requires en high after release.

## Structure
- Package param_check_pkg:
  - state_e typedef (IDLE, SETTLE, PASS, FAIL, 2-bit).
  - Default constants for SETTLE, TIMEOUT, CNT_W.
- Sub-module stable_counter (W, SETTLE):
  - Holds last_val and run_cnt (width $clog2(SETTLE+1)).
  - Inputs: clk, rst_n, clr, en, val.
  - Outputs: last_val, stable (run_cnt==SETTLE).
- Top holds the FSM, tmo_cnt, and the saturating mismatch counter.

## Test plan
- val=2'b10 constant, en=1 from edge 0 → done=pass=1 after edge 5, fail=0, mismatch_cnt=0.
- val=2'b01 constant → done=fail=1 after edge 5, timeout=0, pass=0.
- val toggling 2'b10/2'b01 every 2 cycles → fail=timeout=1 after edge 32, pass never 1.
- In PASS, val=2'b01 for 3 cycles → fail=1 after the first such edge, pass=0, mismatch_cnt=3, done stays 1.
- CNT_W=2, 5 mismatch cycles in FAIL → mismatch_cnt saturates at 3.
- rst_n=0 mid-SETTLE → all outputs 0 immediately. In PASS, en=0 → done=pass=0 after next edge, mismatch_cnt held.
